agg_seq: RTL and testbench

Sequencer for the aggregation stage of the NNA datapath. Collects a configurable number of signed partial sums over a valid/ready stream, accumulates them with saturation, applies ReLU activation, and presents one result per job to the ALU over a valid/ready handshake. One job produces exactly one output word; it sits between the PE partial-sum stream and the ALU.

---
 rtl/agg_seq.sv | 159 +++++++++++++++
 tb/tb_agg_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/agg_seq.sv
// -----------------------------------------------------------------------------
// agg_seq
//
// Aggregation-stage sequencer. It collects a configured number of signed
// partial sums from the PE stream, accumulates them with per-beat saturation,
// applies ReLU and hands one result per job to the ALU over valid/ready.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   start          job start pulse, honoured only while idle
//   cfg_len        partial sums per job, sampled on an accepted start (0 -> 1)
//   psum_valid     partial-sum beat valid
//   psum_data      signed partial sum
//   psum_ready     high only while accumulating
//   agg_out2alu    ReLU result, held stable while agg_out_valid is high
//   agg_out_acted  1 when the pre-activation sum was strictly positive
//   agg_out_valid  result valid towards the ALU
//   alu_ready      ALU accepts the result
//   busy           high whenever a job is in progress
//   done           one-cycle pulse on the cycle after the result handshake
//
// Every output is a flop, so there is no combinational path from psum_valid
// or alu_ready to any output.
// -----------------------------------------------------------------------------
module agg_seq #(
    parameter int agg_width = 12,
    parameter int cnt_width = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [cnt_width-1:0]        cfg_len,
    input  logic                        psum_valid,
    input  logic signed [agg_width-1:0] psum_data,
    output logic                        psum_ready,
    output logic [agg_width-1:0]        agg_out2alu,
    output logic                        agg_out_acted,
    output logic                        agg_out_valid,
    input  logic                        alu_ready,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_ACT,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic signed [agg_width-1:0] ACC_MAX = {1'b0, {(agg_width-1){1'b1}}};
    localparam logic signed [agg_width-1:0] ACC_MIN = {1'b1, {(agg_width-1){1'b0}}};

    state_t                      state;
    logic signed [agg_width-1:0] acc;
    logic [cnt_width-1:0]        cnt;
    logic [cnt_width-1:0]        len;

    logic                        beat;
    logic [cnt_width-1:0]        cnt_next;
    logic signed [agg_width-1:0] acc_next;

    // Signed add one bit wider than the operands; a carry into the extra bit
    // that disagrees with the operand sign bit means overflow, and the extra
    // bit then tells which rail to clamp to.
    function automatic logic signed [agg_width-1:0] sat_add(
        input logic signed [agg_width-1:0] a,
        input logic signed [agg_width-1:0] b
    );
        logic signed [agg_width:0] sum;
        sum = {a[agg_width-1], a} + {b[agg_width-1], b};
        if (sum[agg_width] != sum[agg_width-1])
            sat_add = sum[agg_width] ? ACC_MIN : ACC_MAX;
        else
            sat_add = sum[agg_width-1:0];
    endfunction

    // psum_ready is the registered copy of "state is ACCUM", so a beat only
    // ever happens while accumulating.
    always_comb begin
        beat     = psum_valid & psum_ready;
        cnt_next = cnt + 1'b1;
        acc_next = sat_add(acc, psum_data);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            acc           <= '0;
            cnt           <= '0;
            len           <= '0;
            psum_ready    <= 1'b0;
            agg_out2alu   <= '0;
            agg_out_acted <= 1'b0;
            agg_out_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_ACCUM;
                        len        <= (cfg_len == '0) ? cnt_width'(1) : cfg_len;
                        acc        <= '0;
                        cnt        <= '0;
                        psum_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                S_ACCUM: begin
                    if (beat) begin
                        acc <= acc_next;
                        cnt <= cnt_next;
                        if (cnt_next == len) begin
                            state      <= S_ACT;
                            psum_ready <= 1'b0;
                        end
                    end
                end

                S_ACT: begin
                    agg_out2alu   <= acc[agg_width-1] ? '0 : acc;
                    agg_out_acted <= (acc > 0);
                    agg_out_valid <= 1'b1;
                    state         <= S_OUT;
                end

                S_OUT: begin
                    // Result and flag stay untouched here, so they hold
                    // through any ALU stall.
                    if (alu_ready) begin
                        agg_out_valid <= 1'b0;
                        done          <= 1'b1;
                        state         <= S_DONE;
                    end
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state         <= S_IDLE;
                    psum_ready    <= 1'b0;
                    agg_out_valid <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_agg_seq.sv
// -----------------------------------------------------------------------------
// tb_agg_seq
//
// Directed bench for agg_seq. Stimulus pushes the hand-computed result of each
// completed job into a queue; an independent monitor pops and compares on every
// result handshake and checks that the result holds steady during ALU stalls.
// -----------------------------------------------------------------------------
module tb_agg_seq;

    localparam int AW = 12;
    localparam int CW = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [CW-1:0]        cfg_len;
    logic                 psum_valid;
    logic signed [AW-1:0] psum_data;
    logic                 psum_ready;
    logic [AW-1:0]        agg_out2alu;
    logic                 agg_out_acted;
    logic                 agg_out_valid;
    logic                 alu_ready;
    logic                 busy;
    logic                 done;

    typedef struct {
        int unsigned data;
        int unsigned acted;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_hs    = 0;
    logic        held_valid = 1'b0;
    logic [AW:0] held_data;
    logic        held_acted;

    agg_seq #(.agg_width(AW), .cnt_width(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_len       (cfg_len),
        .psum_valid    (psum_valid),
        .psum_data     (psum_data),
        .psum_ready    (psum_ready),
        .agg_out2alu   (agg_out2alu),
        .agg_out_acted (agg_out_acted),
        .agg_out_valid (agg_out_valid),
        .alu_ready     (alu_ready),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: runs on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            held_valid <= 1'b0;
        end else if (agg_out_valid) begin
            if (held_valid) begin
                check("stall_data_stable", agg_out2alu, held_data);
                check("stall_acted_stable", agg_out_acted, held_acted);
            end
            if (alu_ready) begin
                n_hs++;
                held_valid <= 1'b0;
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("result_data", agg_out2alu, e.data);
                    check("result_acted", agg_out_acted, e.acted);
                end
            end else begin
                held_valid <= 1'b1;
                held_data  <= {1'b0, agg_out2alu};
                held_acted <= agg_out_acted;
            end
        end
    end

    // NOTE: inputs change #1 after the rising edge so the DUT never races the
    // bench on the sampling edge.
    task automatic start_job(input int len);
        @(posedge clk); #1;
        start   = 1'b1;
        cfg_len = CW'(len);
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic send_beat(input int d);
        psum_valid = 1'b1;
        psum_data  = AW'(d);
        @(posedge clk); #1;
        psum_valid = 1'b0;
        psum_data  = 12'sd100;
    endtask

    task automatic push_exp(input int unsigned d, input int unsigned a);
        exp_t e;
        e.data  = d;
        e.acted = a;
        sb_q.push_back(e);
    endtask

    // Called #1 after the last beat's edge, with alu_ready high: walks
    // ACT, OUT, DONE, IDLE and presents start during DONE, which must be ignored.
    task automatic check_tail(input string tag);
        @(negedge clk);
        check({tag, "_act_valid"}, agg_out_valid, 0);
        check({tag, "_act_ready"}, psum_ready, 0);
        check({tag, "_act_busy"}, busy, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_out_valid"}, agg_out_valid, 1);
        check({tag, "_out_ready"}, psum_ready, 0);
        @(posedge clk); #1;
        start = 1'b1;
        @(negedge clk);
        check({tag, "_done_valid"}, agg_out_valid, 0);
        check({tag, "_done_pulse"}, done, 1);
        check({tag, "_done_ready"}, psum_ready, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check({tag, "_idle_done"}, done, 0);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_ready"}, psum_ready, 0);
    endtask

    task automatic wait_valid(input string tag);
        int i;
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (agg_out_valid) break;
        end
        check({tag, "_valid_timeout"}, (i < 50) ? 1 : 0, 1);
    endtask

    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check({tag, "_done_timeout"}, (i < 50) ? 1 : 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        cfg_len    = '0;
        psum_valid = 1'b0;
        psum_data  = '0;
        alu_ready  = 1'b1;
        #12;
        check("rst_ready", psum_ready, 0);
        check("rst_valid", agg_out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-ACCUM, then a minimum-length job.
        start_job(4);
        send_beat(5);
        send_beat(6);
        #2 rst = 1'b1;
        #1;
        check("midrst_ready", psum_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_valid", agg_out_valid, 0);
        check("midrst_data", agg_out2alu, 0);
        check("midrst_acted", agg_out_acted, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        start_job(1);
        push_exp(7, 1);
        send_beat(7);
        check_tail("len1");

        // Basic job; cfg_len change after latch must not matter.
        start_job(3);
        cfg_len = 8'd1;
        push_exp(6, 1);
        send_beat(1);
        send_beat(3);
        send_beat(2);
        check_tail("basic");

        // Positive saturation.
        start_job(2);
        push_exp(2047, 1);
        send_beat(1024);
        send_beat(2047);
        check_tail("satpos");

        // Negative saturation then pull back: -2048 + 50 = -1998.
        start_job(3);
        push_exp(0, 0);
        send_beat(-2048);
        send_beat(-100);
        send_beat(50);
        check_tail("satneg");

        // ReLU at exactly zero.
        start_job(2);
        push_exp(0, 0);
        send_beat(5);
        send_beat(-5);
        check_tail("zero");

        // Gaps on the input stream and a 5-cycle ALU stall: 10 - 3 + 20 + 4 = 31.
        alu_ready = 1'b0;
        start_job(4);
        push_exp(31, 1);
        send_beat(10);
        @(posedge clk); #1;
        send_beat(-3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        send_beat(20);
        @(posedge clk); #1;
        send_beat(4);
        wait_valid("bp");
        psum_valid = 1'b1;
        psum_data  = 12'sd100;
        for (int k = 0; k < 5; k++) begin
            check("bp_stall_ready", psum_ready, 0);
            check("bp_stall_valid", agg_out_valid, 1);
            @(posedge clk); #1;
            @(negedge clk);
        end
        psum_valid = 1'b0;
        @(posedge clk); #1;
        alu_ready = 1'b1;
        wait_done("bp");

        // cfg_len = 0 runs as one beat; start during OUT is ignored.
        alu_ready = 1'b0;
        start_job(0);
        push_exp(9, 1);
        send_beat(9);
        wait_valid("len0");
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        alu_ready = 1'b1;
        wait_done("len0");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("nojob_busy", busy, 0);
            check("nojob_ready", psum_ready, 0);
        end

        check("handshake_count", n_hs, 7);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
